// File: rtl/seq_frame_tx_pkg.sv
// Shared definitions for the framed serial transmitter and its matching sync detector.
package seq_frame_tx_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StSync   = 2'b01,
    StData   = 2'b10,
    StParity = 2'b11
  } tx_state_e;

  localparam int unsigned             SYNC_W_DEF   = 4;
  localparam logic [SYNC_W_DEF-1:0]   SYNC_PAT_DEF = 4'b1001;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/frame_piso.sv
// Loadable parallel-in serial-out shift register; even parity is captured on load.
module frame_piso #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              msb_o,
  output logic              parity_o
);

  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              parity_q, parity_d;

  always_comb begin
    sreg_d   = sreg_q;
    parity_d = parity_q;
    if (load_i) begin
      sreg_d   = data_i;
      parity_d = ^data_i;
    end else if (shift_i) begin
      sreg_d = sreg_q << 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      parity_q <= parity_d;
    end
  end

  assign msb_o    = sreg_q[DATA_W-1];
  assign parity_o = parity_q;

endmodule

// File: rtl/seq_frame_tx.sv
// Framed serial transmitter: sync header, MSB-first payload, even parity, back-to-back capable.
module seq_frame_tx
  import seq_frame_tx_pkg::*;
#(
  parameter int unsigned        DATA_W   = 8,
  parameter int unsigned        SYNC_W   = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0]  SYNC_PAT = SYNC_PAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              ser_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CntMax  = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned CntW    = clog2_min1(CntMax);
  localparam int unsigned SyncIdW = clog2_min1(SYNC_W);

  tx_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready;
  logic              hs;
  logic              load;
  logic              shift;
  logic              piso_msb;
  logic              piso_parity;
  logic [SYNC_W-1:0] sync_pat;

  assign sync_pat = SYNC_PAT;

  // Ready only in IDLE/PARITY, and held low while reset is asserted.
  assign ready    = !rst && ((state_q == StIdle) || (state_q == StParity));
  assign hs       = tx_valid && ready;
  assign tx_ready = ready;

  frame_piso #(
    .DATA_W (DATA_W)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .shift_i  (shift),
    .data_i   (tx_data),
    .msb_o    (piso_msb),
    .parity_o (piso_parity)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    shift      = 1'b0;
    ser_out    = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (hs) begin
          state_d = StSync;
          cnt_d   = CntW'(SYNC_W - 1);
          load    = 1'b1;
        end
      end
      StSync: begin
        busy    = 1'b1;
        ser_out = sync_pat[cnt_q[SyncIdW-1:0]];
        if (cnt_q == '0) begin
          state_d = StData;
          cnt_d   = CntW'(DATA_W - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StData: begin
        busy    = 1'b1;
        ser_out = piso_msb;
        shift   = 1'b1;
        if (cnt_q == '0) begin
          state_d = StParity;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StParity: begin
        busy       = 1'b1;
        ser_out    = piso_parity;
        frame_done = 1'b1;
        if (hs) begin
          state_d = StSync;
          cnt_d   = CntW'(SYNC_W - 1);
          load    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Randomised and directed checks of seq_frame_tx against a queue-of-bits frame model.
module tb_seq_frame_tx;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SYNC_W   = 4;
  localparam logic [3:0]  SYNC_PAT = 4'b1001;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready;
  logic              ser_out;
  logic              busy;
  logic              frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  bit mq[$];   // bits still to be sent, front is the bit currently on the line
  bit log[$];  // ser_out as observed each cycle

  seq_frame_tx #(
    .DATA_W   (DATA_W),
    .SYNC_W   (SYNC_W),
    .SYNC_PAT (SYNC_PAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ser_out    (ser_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: compare outputs with the model, drive inputs, advance model across the edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d);
    bit acc;
    @(negedge clk);
    check("ser_out",    32'(ser_out),    32'((mq.size() > 0) ? mq[0] : 1'b0));
    check("busy",       32'(busy),       32'(mq.size() > 0));
    check("frame_done", 32'(frame_done), 32'(mq.size() == 1));
    check("tx_ready",   32'(tx_ready),   32'(mq.size() <= 1));
    log.push_back(ser_out);
    tx_valid = v;
    tx_data  = d;
    acc = v && (mq.size() <= 1);
    @(posedge clk);
    if (mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      for (int i = SYNC_W - 1; i >= 0; i--) mq.push_back(SYNC_PAT[i]);
      for (int i = DATA_W - 1; i >= 0; i--) mq.push_back(d[i]);
      mq.push_back(^d);
    end
  endtask

  function automatic logic [31:0] log_bits(input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], 1'(log[i])};
    return r;
  endfunction

  initial begin
    int hits;
    // Outputs while reset is held.
    #2;
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(frame_done), 32'd0);
    check("rst_ready",   32'(tx_ready), 32'd0);
    #10 rst = 1'b0;

    // Single frame 8'hA5.
    step(1'b0, '0);
    step(1'b1, 8'hA5);
    log.delete();
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00);
    check("a5_frame", log_bits(14), 32'({13'b1001_10100101_0, 1'b0}));

    // Back-to-back 8'h01 then 8'hFF with valid held through the first frame.
    step(1'b1, 8'h01);
    log.delete();
    for (int i = 0; i < 13; i++) step(1'b1, 8'hFF);
    for (int i = 0; i < 13; i++) step(1'b0, 8'h00);
    check("b2b_frames", log_bits(26), 32'(26'b1001_00000001_1_1001_11111111_0));
    step(1'b0, 8'h00);

    // Valid pulsed during DATA is ignored.
    step(1'b1, 8'h5A);
    log.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
    check("ign_frame", log_bits(17), 32'({13'b1001_01011010_0, 4'b0000}));

    // Reset asserted in the 6th frame cycle acts without a clock edge.
    step(1'b1, 8'h33);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ser_out", 32'(ser_out), 32'd0);
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_ready",   32'(tx_ready), 32'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h80);
    log.delete();
    for (int i = 0; i < 14; i++) step(1'b0, 8'h00);
    check("post_rst_frame", log_bits(14), 32'({13'b1001_10000000_1, 1'b0}));

    // Loop-back: sync pattern also appears twice inside payload 8'h99.
    step(1'b1, 8'h99);
    log.delete();
    for (int i = 0; i < 13; i++) step(1'b0, 8'h00);
    hits = 0;
    for (int i = 3; i < 13; i++)
      if ({log[i-3], log[i-2], log[i-1], log[i]} == SYNC_PAT) hits++;
    check("loopback_hits", 32'(hits), 32'd3);
    step(1'b0, 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) == 0), 8'($urandom));
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx.md
SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame.
REQ-002 Parameter SYNC_PAT, default 4'b1001, sync header sent MSB first.
REQ-003 Parameter SYNC_W, default 4, width of SYNC_PAT.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1  reset; asynchronous, active-high.
REQ-006 Port tx_valid  input  1  payload offered.
REQ-007 Port tx_data  input  DATA_W  payload; sampled only on handshake.
REQ-008 Port tx_ready  output  1  block can accept a payload this cycle.
REQ-009 Port ser_out  output  1  serial line, one bit per clk.
REQ-010 Port busy  output  1  a frame is in progress (any state other than IDLE).
REQ-011 Port frame_done  output  1  high for exactly the cycle the parity bit is driven.

Function
REQ-012 Frame format SHALL be: SYNC_W sync bits (SYNC_PAT, MSB first), then DATA_W payload bits (MSB first), then 1 even-parity bit over the payload. That is SYNC_W+DATA_W+1 cycles, 13 at the default parameters.
REQ-013 FSM states SHALL be IDLE, SYNC, DATA and PARITY. Outputs are Moore: decoded from the state and bit counter only.
REQ-014 IDLE: ser_out=0, tx_ready=1, busy=0.
REQ-015 Handshake SHALL occur when tx_valid && tx_ready at a rising edge. On handshake, tx_data SHALL be latched into the shift register and its parity computed.
REQ-016 IDLE with handshake -> SYNC, bit counter=SYNC_W-1. The first sync bit SHALL appear on ser_out the cycle after the handshake (latency 1).
REQ-017 SYNC: ser_out=SYNC_PAT[counter]. The counter decrements each cycle; at 0 -> DATA with counter=DATA_W-1.
REQ-018 DATA: ser_out=shift register MSB. The register shifts left each cycle; at counter 0 -> PARITY.
REQ-019 PARITY: ser_out=latched parity, frame_done=1, tx_ready=1.
REQ-020 PARITY with handshake -> SYNC directly (back-to-back). There is no idle gap, so sustained throughput is one frame per SYNC_W+DATA_W+1 cycles.
REQ-021 PARITY without handshake -> IDLE.
REQ-022 tx_ready SHALL be 0 in SYNC and DATA. tx_valid asserted there SHALL be ignored and its data SHALL NOT be latched.
REQ-023 tx_data changing while tx_ready=0 SHALL NOT affect the frame in flight.
REQ-024 Payload containing SYNC_PAT SHALL be transmitted unaltered; no stuffing or escaping is performed.
REQ-025 Illegal state encoding SHALL recover to IDLE on the next edge, with ser_out=0.

Reset
REQ-026 Asserting rst SHALL immediately force state IDLE, counter 0, shift register 0 and parity 0, independent of clk.
REQ-027 While rst is high: ser_out=0, busy=0, frame_done=0 and tx_ready=0.
REQ-028 tx_ready SHALL be 1 from the first edge after rst deasserts.
REQ-029 Reset mid-frame SHALL abandon the frame. No partial-frame resumption occurs; the next frame restarts with a full sync header.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=2'b00, SYNC=2'b01, DATA=2'b10, PARITY=2'b11) and the default SYNC_PAT/SYNC_W constants, so the sequence-detector side uses the same pattern.
REQ-031 One sub-module, frame_piso, SHALL implement the loadable DATA_W parallel-in serial-out shift register with parity-on-load. The FSM and counter remain in seq_frame_tx.

Verification
REQ-032 Single frame: after reset, tx_data=8'hA5 with tx_valid for 1 cycle -> ser_out = 1,0,0,1, 1,0,1,0,0,1,0,1, 0 over the next 13 cycles, then 0. frame_done is high on cycle 13 only.
REQ-033 Back-to-back: 8'h01 then 8'hFF, with tx_valid held high -> 26 consecutive bits: 1001 00000001 1, then 1001 11111111 0, with no gap. The second handshake occurs in the first frame's PARITY cycle.
REQ-034 Ignored valid: pulse tx_valid with 8'h3C during the DATA state -> the frame in flight is unchanged, no extra frame is sent, and ser_out returns to 0.
REQ-035 Mid-frame reset: assert rst during the 6th frame cycle -> ser_out=0 and busy=0 immediately, with no clk edge needed. After release, 8'h80 -> full 1001 10000000 1 frame.
REQ-036 Loop-back: drive ser_out into the 1001 sequence detector -> detect is high the cycle after each 4th sync bit. Payload 8'h99 also raises detect twice and is accepted as correct.
